// File: rtl/c512to8.sv
`default_nettype none
// ============================================================================
// Module   : c512to8
// Function : Wide-to-byte serializer. Accepts DATA_WIDTH-bit words with a
//            control word (SOP bit 31, EOP bit 30, byte count [5:0]) and emits
//            them MSB byte first, one byte per cycle, with newpkt/pktend
//            framing and a completed-packet counter.
// Option   : define C512TO8_IPG_EN to force one idle GAP cycle after every
//            packet end.
// Revision : 1.0 - initial release
// ============================================================================
module c512to8 #(
   parameter int DATA_WIDTH = 480,
   parameter int CTRL_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_wr,
   input  logic [CTRL_WIDTH-1:0] in_ctl,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_rdy,
   input  logic                  pause,
   output logic [7:0]            data,
   output logic                  datavalid,
   output logic                  newpkt,
   output logic                  pktend,
   output logic [7:0]            pktcount,
   output logic                  err
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int IW     = $clog2(NBYTES + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1
`ifdef C512TO8_IPG_EN
      , S_GAP = 2'd2
`endif
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] sreg;      // remaining bytes, next byte in the MSBs
   logic [IW-1:0]         idx;       // index of the next byte to emit
   logic [IW-1:0]         n_r;       // effective byte count of the held word
   logic                  sop_r;
   logic                  eop_r;

   logic [5:0]            cnt_field;
   logic                  in_bad;
   logic [IW-1:0]         in_n;
   logic                  last;
   logic                  accept;
   logic                  drop;
   state_t                done_shift;
   state_t                done_idle;
   logic                  ctl_unused;

   assign cnt_field  = in_ctl[5:0];
   assign ctl_unused = ^in_ctl[29:6];
   assign last       = (idx == n_r - IW'(1));
   assign accept     = in_wr && in_rdy;
   assign drop       = in_wr && !in_rdy;

   // Effective byte count: out-of-range fields fall back to a full word
   always_comb begin
      in_bad = (cnt_field == 6'd0) || (int'(cnt_field) > NBYTES);
      in_n   = in_bad ? IW'(NBYTES) : IW'(cnt_field);
   end

   // State to enter after a word's final byte when no new word follows
   always_comb begin
      done_shift = S_IDLE;
      done_idle  = S_IDLE;
`ifdef C512TO8_IPG_EN
      if (eop_r)     done_shift = S_GAP;
      if (in_ctl[30]) done_idle = S_GAP;
`endif
   end

   // Ready in IDLE, and on the unpaused last-byte cycle for gap-free reload
   always_comb begin
      in_rdy = 1'b0;
      case (state)
         S_IDLE:  in_rdy = 1'b1;
`ifdef C512TO8_IPG_EN
         S_SHIFT: in_rdy = !pause && last && !eop_r;
`else
         S_SHIFT: in_rdy = !pause && last;
`endif
         default: in_rdy = 1'b0;
      endcase
   end

   // Serializer FSM with registered byte outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         sreg      <= '0;
         idx       <= '0;
         n_r       <= '0;
         sop_r     <= 1'b0;
         eop_r     <= 1'b0;
         data      <= 8'd0;
         datavalid <= 1'b0;
         newpkt    <= 1'b0;
         pktend    <= 1'b0;
         pktcount  <= 8'd0;
         err       <= 1'b0;
      end else begin
         datavalid <= 1'b0;
         newpkt    <= 1'b0;
         pktend    <= 1'b0;
         if (drop || (accept && in_bad))
            err <= 1'b1;

         case (state)
            S_IDLE: begin
               if (accept) begin
                  sop_r <= in_ctl[31];
                  eop_r <= in_ctl[30];
                  n_r   <= in_n;
                  if (!pause) begin
                     // byte 0 goes out on the acceptance edge
                     data      <= in_data[DATA_WIDTH-1 -: 8];
                     datavalid <= 1'b1;
                     newpkt    <= in_ctl[31];
                     pktend    <= in_ctl[30] && (in_n == IW'(1));
                     if (in_ctl[30] && (in_n == IW'(1)))
                        pktcount <= pktcount + 8'd1;
                     sreg  <= in_data << 8;
                     idx   <= IW'(1);
                     state <= (in_n == IW'(1)) ? done_idle : S_SHIFT;
                  end else begin
                     sreg  <= in_data;
                     idx   <= '0;
                     state <= S_SHIFT;
                  end
               end
            end

            S_SHIFT: begin
               if (!pause) begin
                  data      <= sreg[DATA_WIDTH-1 -: 8];
                  datavalid <= 1'b1;
                  newpkt    <= (idx == '0) && sop_r;
                  pktend    <= last && eop_r;
                  if (last && eop_r)
                     pktcount <= pktcount + 8'd1;
                  sreg <= sreg << 8;
                  idx  <= idx + IW'(1);
                  if (last) begin
                     if (accept) begin
                        sreg  <= in_data;
                        sop_r <= in_ctl[31];
                        eop_r <= in_ctl[30];
                        n_r   <= in_n;
                        idx   <= '0;
                     end else begin
                        state <= done_shift;
                     end
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_c512to8.sv
`default_nettype none
// ============================================================================
// Module   : tb_c512to8
// Function : Self-checking bench for c512to8. Every accepted word is expanded
//            into an expected byte list (byte, newpkt, pktend); a monitor pops
//            it on each valid output byte and tracks pktcount and err.
// Revision : 1.0 - initial release
// ============================================================================
module tb_c512to8;

   localparam int DW = 480;
   localparam int NB = 60;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_wr = 1'b0;
   logic [31:0]   in_ctl = '0;
   logic [DW-1:0] in_data = '0;
   logic          in_rdy;
   logic          pause = 1'b0;
   logic [7:0]    data;
   logic          datavalid;
   logic          newpkt;
   logic          pktend;
   logic [7:0]    pktcount;
   logic          err;

   typedef struct {
      logic [7:0] b;
      logic       np;
      logic       pe;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   logic [7:0] cnt_model = 8'd0;
   logic       exp_err   = 1'b0;
   logic       mon_en    = 1'b0;
   logic       mon_pause = 1'b0;
   logic       prev_end  = 1'b0;
   int         run       = 0;
   int         max_run   = 0;
   int         total     = 0;
   int         bad       = 0;

   c512to8 dut (
      .clk       (clk),
      .rst       (rst),
      .in_wr     (in_wr),
      .in_ctl    (in_ctl),
      .in_data   (in_data),
      .in_rdy    (in_rdy),
      .pause     (pause),
      .data      (data),
      .datavalid (datavalid),
      .newpkt    (newpkt),
      .pktend    (pktend),
      .pktcount  (pktcount),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      w = '0;
      for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom();
      return w;
   endfunction

   // Expand an accepted word into the bytes it must produce
   task automatic push_word(input logic [31:0] ctl, input logic [DW-1:0] d);
      int   n;
      exp_t e;
      n = int'(ctl[5:0]);
      if (n == 0 || n > NB) begin
         n = NB;
         exp_err = 1'b1;
      end
      for (int i = 0; i < n; i++) begin
         e.b  = d[DW-1-8*i -: 8];
         e.np = (i == 0) && ctl[31];
         e.pe = (i == n - 1) && ctl[30];
         exp_q.push_back(e);
      end
   endtask

   // Wait for in_rdy, then write one word on that cycle
   task automatic send(input logic [31:0] ctl, input logic [DW-1:0] d, input int pct);
      bit done;
      done = 1'b0;
      for (int t = 0; t < 1000 && !done; t++) begin
         @(negedge clk);
         in_wr = 1'b0;
         pause = ($urandom_range(99) < pct);
         #1;
         if (in_rdy) begin
            in_wr   = 1'b1;
            in_ctl  = ctl;
            in_data = d;
            push_word(ctl, d);
            done    = 1'b1;
         end
      end
      if (!done) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n, input int pct);
      repeat (n) begin
         @(negedge clk);
         in_wr = 1'b0;
         pause = ($urandom_range(99) < pct);
      end
   endtask

   // Output monitor: byte order, framing, pause hold, counters
   always @(posedge clk) begin
      mon_pause = pause;
      #1;
      if (mon_en) begin
         if (mon_pause) check("pause_hold", 32'(datavalid), 32'd0);
`ifdef C512TO8_IPG_EN
         if (prev_end) check("ipg_gap", 32'(datavalid), 32'd0);
`endif
         if (datavalid) begin
            run++;
            if (run > max_run) max_run = run;
            if (exp_q.size() == 0) begin
               check("extra_byte", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("data", 32'(data), 32'(mon_e.b));
               check("newpkt", 32'(newpkt), 32'(mon_e.np));
               check("pktend", 32'(pktend), 32'(mon_e.pe));
               if (mon_e.pe) cnt_model = cnt_model + 8'd1;
            end
         end else begin
            run = 0;
            check("newpkt_idle", 32'(newpkt), 32'd0);
            check("pktend_idle", 32'(pktend), 32'd0);
         end
         check("pktcount", 32'(pktcount), 32'(cnt_model));
         check("err", 32'(err), 32'(exp_err));
         prev_end = datavalid && pktend;
      end
   end

   initial begin
      logic [DW-1:0] d;
      logic [31:0]   ctl;
      logic [5:0]    cnt;
      logic          sop;
      logic          eop;

      // reset values
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_rdy", 32'(in_rdy), 32'd1);
      check("rst_data", 32'(data), 32'd0);
      check("rst_dv", 32'(datavalid), 32'd0);
      check("rst_newpkt", 32'(newpkt), 32'd0);
      check("rst_pktend", 32'(pktend), 32'd0);
      check("rst_pktcount", 32'(pktcount), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      mon_en = 1'b1;

      // single 4-byte packet AA BB CC DD
      d = '0;
      d[DW-1 -: 32] = 32'hAABBCCDD;
      send(32'hC000_0004, d, 0);
      @(posedge clk);
      #2;
      check("latency_dv", 32'(datavalid), 32'd1);
      check("latency_data", 32'(data), 32'hAA);
      idle(8, 0);
      check("pkt1_count", 32'(pktcount), 32'd1);
      check("rdy_back", 32'(in_rdy), 32'd1);

      // three-word packet, 125 contiguous bytes
      max_run = 0;
      send(32'h8000_003C, rand_word(), 0);
      send(32'h0000_003C, rand_word(), 0);
      send(32'h4000_0005, rand_word(), 0);
      idle(10, 0);
      check("contig_run", 32'(max_run), 32'd125);
      check("contig_drain", 32'(exp_q.size()), 32'd0);

      // pause for 3 cycles around byte 10
      send(32'hC000_003C, rand_word(), 0);
      idle(10, 0);
      idle(3, 100);
      idle(70, 0);
      check("pause_drain", 32'(exp_q.size()), 32'd0);

      // count field 0 -> full word and err
      send(32'hC000_0000, rand_word(), 0);
      idle(70, 0);
      check("cnt0_drain", 32'(exp_q.size()), 32'd0);
      check("cnt0_err", 32'(err), 32'd1);

      // reset at byte 20 of a packet
      send(32'hC000_003C, rand_word(), 0);
      idle(20, 0);
      @(negedge clk);
      mon_en = 1'b0;
      rst    = 1'b0;
      #1;
      check("mid_rst_dv", 32'(datavalid), 32'd0);
      check("mid_rst_data", 32'(data), 32'd0);
      check("mid_rst_pktend", 32'(pktend), 32'd0);
      check("mid_rst_pktcount", 32'(pktcount), 32'd0);
      check("mid_rst_err", 32'(err), 32'd0);
      check("mid_rst_rdy", 32'(in_rdy), 32'd1);
      exp_q.delete();
      cnt_model = 8'd0;
      exp_err   = 1'b0;
      prev_end  = 1'b0;
      run       = 0;
      idle(2, 0);
      @(negedge clk);
      rst    = 1'b1;
      mon_en = 1'b1;
      send(32'hC000_0008, rand_word(), 0);
      idle(15, 0);
      check("post_rst_count", 32'(pktcount), 32'd1);

      // write while busy is dropped and sets err
      send(32'hC000_003C, rand_word(), 0);
      idle(3, 0);
      @(negedge clk);
      in_wr = 1'b0;
      pause = 1'b0;
      #1;
      check("busy_rdy", 32'(in_rdy), 32'd0);
      in_wr   = 1'b1;
      in_ctl  = 32'hC000_0004;
      in_data = rand_word();
      exp_err = 1'b1;
      idle(70, 0);
      check("drop_drain", 32'(exp_q.size()), 32'd0);
      check("drop_err", 32'(err), 32'd1);

      // randomized traffic with random pause
      for (int w = 0; w < 300; w++) begin
         sop = 1'($urandom_range(1));
         eop = 1'($urandom_range(1));
         cnt = 6'($urandom_range(60, 1));
         if ($urandom_range(99) < 5) cnt = ($urandom_range(1) == 0) ? 6'd0 : 6'($urandom_range(63, 61));
         ctl = {sop, eop, 24'd0, cnt};
         send(ctl, rand_word(), 20);
         if ($urandom_range(3) == 0) idle(int'($urandom_range(2)), 20);
      end

      // drain with a bound
      for (int t = 0; t < 3000 && exp_q.size() > 0; t++) idle(1, 0);
      idle(5, 0);
      check("final_drain", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
